// File: rtl/fp_accum_pkg.sv
// Shared types and constants for the single-precision accumulation sequencer.
//   state_t : sequencer FSM states
//   FP_W    : IEEE-754 single-precision word width
//   FP_ZERO : +0.0 encoding, accumulator start value
//   FP_PINF : +inf encoding
package fp_accum_pkg;

    localparam int          FP_W    = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        ACCEPT,
        ISSUE,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/fp_accum_seq.sv
// Sums a stream of `len` single-precision operands by driving an external
// two-register fpAdder with {acc, operand} and writing each result back.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, len            launch a run of `len` operands (sampled in IDLE)
//   in_data/valid/ready   operand stream handshake
//   add_a/b/en            to adder inputs and enable
//   add_result/add_ovf    from adder output register
//   sum, sum_ovf          final sum (held) and sticky overflow
//   busy, done            not-IDLE indicator, one-cycle result strobe
module fp_accum_seq
    import fp_accum_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [FP_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [FP_W-1:0]  add_a,
    output logic [FP_W-1:0]  add_b,
    output logic             add_en,
    input  logic [FP_W-1:0]  add_result,
    input  logic             add_ovf,
    output logic [FP_W-1:0]  sum,
    output logic             sum_ovf,
    output logic             busy,
    output logic             done
);

    state_t            state_q, state_d;
    logic [FP_W-1:0]   acc_q, acc_d;
    logic [FP_W-1:0]   opnd_q, opnd_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [FP_W-1:0]   sum_q, sum_d;
    logic              sum_ovf_q, sum_ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= FP_ZERO;
            opnd_q    <= FP_ZERO;
            cnt_q     <= '0;
            sum_q     <= FP_ZERO;
            sum_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            sum_q     <= sum_d;
            sum_ovf_q <= sum_ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        cnt_d     = cnt_q;
        sum_d     = sum_q;
        sum_ovf_d = sum_ovf_q;
        in_ready  = 1'b0;
        add_en    = 1'b0;
        add_a     = FP_ZERO;
        add_b     = FP_ZERO;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d     = FP_ZERO;
                    cnt_d     = len;
                    sum_ovf_d = 1'b0;
                    state_d   = (len == '0) ? DONE : ACCEPT;
                end
            end
            ACCEPT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opnd_d  = in_data;
                    state_d = ISSUE;
                end
            end
            // Operands stay stable across both enabled cycles: the adder
            // latches them after ISSUE and registers its result after WAIT.
            ISSUE: begin
                add_a   = acc_q;
                add_b   = opnd_q;
                add_en  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                add_a   = acc_q;
                add_b   = opnd_q;
                add_en  = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                acc_d     = add_result;
                sum_ovf_d = sum_ovf_q | add_ovf;
                cnt_d     = cnt_q - LEN_W'(1);
                state_d   = (cnt_q == LEN_W'(1)) ? DONE : ACCEPT;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Capture the next accumulator value on the edge into DONE, so the
        // sum is already visible while done is high (also covers len==0).
        if (state_d == DONE)
            sum_d = acc_d;
    end

    assign sum     = sum_q;
    assign sum_ovf = sum_ovf_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_fp_accum_seq.sv
module tb_fp_accum_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] add_a, add_b;
    logic        add_en;
    logic [31:0] add_result = '0;
    logic        add_ovf = 1'b0;
    logic [31:0] sum;
    logic        sum_ovf, busy, done;

    int ncmp = 0;
    int nfail = 0;
    int ec = 0;
    int en_cnt = 0;

    typedef struct {
        logic [31:0] s;
        logic        ovf;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fp_accum_seq #(.LEN_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .add_a(add_a), .add_b(add_b), .add_en(add_en),
        .add_result(add_result), .add_ovf(add_ovf),
        .sum(sum), .sum_ovf(sum_ovf), .busy(busy), .done(done)
    );

    // Reference adder for positive operands: truncating, overflow flag on
    // carry-normalise and on exponent overflow (result forced to +inf).
    function automatic logic [32:0] fadd(input logic [31:0] a_i, input logic [31:0] b_i);
        logic [31:0] a, b, t;
        logic [24:0] ma, mb, s;
        logic [8:0]  e;
        int          sh;
        logic        cy;
        a = a_i; b = b_i;
        if (a[30:0] == 31'd0) return {1'b0, b};
        if (b[30:0] == 31'd0) return {1'b0, a};
        if (a[30:23] < b[30:23]) begin t = a; a = b; b = t; end
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]};
        sh = int'(a[30:23]) - int'(b[30:23]);
        mb = (sh > 24) ? 25'd0 : (mb >> sh);
        s  = ma + mb;
        e  = {1'b0, a[30:23]};
        cy = s[24];
        if (cy) begin s = s >> 1; e = e + 9'd1; end
        if (e >= 9'd255) return {1'b1, fp_accum_pkg::FP_PINF};
        return {cy, a[31], e[7:0], s[22:0]};
    endfunction

    // Two-register adder: inputs latched, then result registered, both on add_en.
    logic [31:0] ar = '0, br = '0;
    always @(posedge clk) begin
        ec <= ec + 1;
        if (add_en) begin
            ar <= add_a;
            br <= add_b;
            {add_ovf, add_result} <= fadd(ar, br);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest expected run.
    always @(negedge clk) begin
        if (add_en) en_cnt++;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("sum_ovf", 64'(sum_ovf), 64'(e.ovf));
                chk("done_cycle", 64'(ec), 64'(e.cyc));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] l, input logic [31:0] s, input logic o, input int stall);
        exp_t e;
        e.s = s; e.ovf = o; e.cyc = ec + 1 + 4 * int'(l) + stall;
        sb.push_back(e);
        start = 1'b1; len = l;
        tick(1);
        start = 1'b0;
    endtask

    // Offer one operand; with gap>0 the block is first held in ACCEPT with
    // in_valid low for gap cycles.
    task automatic send(input logic [31:0] d, input int gap);
        int n = 0;
        in_data = d;
        in_valid = (gap == 0);
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("accept_timeout", 64'(in_ready), 64'(1));
        for (int i = 0; i < gap; i++) begin
            chk("stall_ready_en", 64'({in_ready, add_en}), 64'(2'b10));
            @(negedge clk);
        end
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) chk("run_timeout", 64'(sb.size()), 64'(0));
        tick(1);
    endtask

    task automatic chk_zero_outputs(input string tag);
        @(negedge clk);
        chk(tag, 64'({in_ready, add_en, busy, done, sum_ovf}), 64'(0));
        chk({tag, "_data"}, {sum, add_a | add_b}, 64'(0));
    endtask

    initial begin
        int en0;
        // Reset state
        tick(2);
        chk_zero_outputs("reset");
        reset = 1'b0;
        tick(1);

        // 1.0 + 0.5 + 0.25, in_valid always ready
        start_run(8'd3, 32'h3FE0_0000, 1'b0, 0);
        send(32'h3F80_0000, 0);
        send(32'h3F00_0000, 0);
        send(32'h3E80_0000, 0);
        wait_idle();

        // len == 0: immediate done, zero sum, adder untouched
        en0 = en_cnt;
        start_run(8'd0, 32'h0, 1'b0, 0);
        wait_idle();
        chk("len0_add_en", 64'(en_cnt), 64'(en0));

        // Overflow to +inf
        start_run(8'd2, 32'h7F80_0000, 1'b1, 0);
        send(32'h7F00_0000, 0);
        send(32'h7F00_0000, 0);
        wait_idle();

        // Source stall of 5 cycles before the second operand
        start_run(8'd2, 32'h4040_0000, 1'b0, 5);
        send(32'h3F80_0000, 0);
        send(32'h4000_0000, 5);
        wait_idle();

        // start pulsed in WAIT must be ignored
        start_run(8'd2, 32'h3FC0_0000, 1'b0, 0);
        send(32'h3F80_0000, 0);       // now in ISSUE
        tick(1);                       // WAIT
        chk("wait_add_en", 64'(add_en), 64'(1));
        start = 1'b1; len = 8'd7;
        tick(1);
        start = 1'b0;
        send(32'h3F00_0000, 0);
        wait_idle();
        tick(2);
        chk("no_restart_busy", 64'(busy), 64'(0));

        // Reset during CAPTURE of operand 2 of 4 aborts without done
        start_run(8'd4, 32'h0, 1'b0, 0);
        send(32'h3F80_0000, 0);
        send(32'h3F80_0000, 0);       // ISSUE of operand 2
        tick(2);                       // CAPTURE
        void'(sb.pop_back());
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_zero_outputs("abort");
        tick(20);

        start_run(8'd1, 32'h4040_0000, 1'b0, 0);
        send(32'h4040_0000, 0);
        wait_idle();

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
